hazard_forward_scoreboard: RTL and testbench
============================================

// Module: hazard_forward_scoreboard
// PURPOSE
//  Parametrised ID-stage hazard unit for the dynamic pipeline: per-operand EXE/MEM/long-unit bypass mux,
//  load-use stall, plus a registered scoreboard tracking writes from a variable-latency long unit (MUL/DIV).
//  Sits between ID decode and the register file; drives ID/EXE stall and operand data into the ID/EXE register.
// PARAMETERS
//  DATA_W    32  operand/result width
//  NUM_SRC   2   source operands checked per instruction (packed buses, operand i = slice i)
//  NREG      32  architectural registers; ADDR_W = $clog2(NREG)
//  MAX_OUT   4   max long-unit ops outstanding (1..15)
//  CNT_W     16  stall-cycle counter width
// PORTS
//  clk           in   1               clock, all state on rising edge
//  rst           in   1               synchronous, active-high reset
//  id_valid      in   1               ID holds a real instruction
//  id_src_addr   in   NUM_SRC*ADDR_W  source register addresses
//  id_src_used   in   NUM_SRC         operand i actually read
//  id_src_rf     in   NUM_SRC*DATA_W  register-file read data
//  id_wr_ena     in   1               ID instruction writes a register
//  id_waddr      in   ADDR_W          ID destination
//  id_is_long    in   1               ID instruction issues to long unit
//  exe_wr_ena    in   1               EXE writes a register
//  exe_waddr     in   ADDR_W          EXE destination
//  exe_wdata     in   DATA_W          EXE result (ALU/JAL npc, pre-selected)
//  exe_is_load   in   1               EXE instruction is a load
//  mem_wr_ena    in   1               MEM writes a register
//  mem_waddr     in   ADDR_W          MEM destination
//  mem_wdata     in   DATA_W          MEM result (load data when mem_is_load)
//  mem_is_load   in   1               MEM instruction is a load
//  mem_load_rdy  in   1               load data on mem_wdata is valid this cycle
//  lu_done       in   1               long unit writing back this cycle
//  lu_waddr      in   ADDR_W          long-unit destination
//  lu_wdata      in   DATA_W          long-unit result
//  src_out       out  NUM_SRC*DATA_W  bypassed operands
//  stall         out  1               hold PC and IF/ID, bubble into EXE
//  stall_cause   out  3               [0] load-use [1] scoreboard RAW [2] WAW/structural
//  pending       out  NREG            scoreboard bits (registered)
//  outstanding   out  4               long ops in flight (registered)
//  stall_cycles  out  CNT_W           saturating count of cycles with id_valid&&stall
//  lu_err        out  1               sticky: lu_done with outstanding==0 or pending[lu_waddr]==0
// BEHAVIOUR
//  Reset: pending=0, outstanding=0, stall_cycles=0, lu_err=0; combinational outputs follow inputs.
//  Operand i (zero latency, combinational), checked only if used and addr!=0; else src_out=id_src_rf:
//   1 exe_wr_ena&&exe_waddr==a: exe_is_load ? stall(cause0), data don't-care : exe_wdata
//   2 elif mem_wr_ena&&mem_waddr==a: (mem_is_load&&!mem_load_rdy) ? stall(cause0) : mem_wdata
//   3 elif lu_done&&lu_waddr==a: lu_wdata (same-cycle completion bypass, no stall)
//   4 elif pending[a]: stall(cause1)
//   5 else id_src_rf
//  WAW/structural (cause2): id_wr_ena&&id_waddr!=0&&pending[id_waddr]&&!(lu_done&&lu_waddr==id_waddr);
//   or id_is_long&&outstanding==MAX_OUT&&!lu_done.
//  stall = id_valid && |stall_cause; stall_cause forced 0 when !id_valid.
//  Issue = id_valid&&id_is_long&&id_wr_ena&&!stall&&id_waddr!=0.
//  Next state: lu_done clears pending[lu_waddr]; issue sets pending[id_waddr]; same reg both -> set wins.
//   outstanding +1 on issue, -1 on lu_done (only if >0), both -> unchanged; never exceeds MAX_OUT.
//  lu_done with outstanding==0 or pending[lu_waddr]==0: state unchanged except lu_err<=1 (held to reset).
//  stall_cycles +1 per stalled cycle, saturates at all-ones.
//  pending[0] is never set; r0 never forwarded or stalled.
//  Reset mid-operation clears scoreboard; long unit is reset with it, late lu_done flags lu_err.
// TESTING
//  T1 EXE ALU wr r5=0x1234, ID reads r5 on src1 -> src_out[1]=0x1234, stall=0.
//  T2 EXE load to r7, ID uses r7 -> stall=1, cause=3'b001; next cycle MEM load, mem_load_rdy=1,
//   data 0xCAFE -> src_out=0xCAFE, stall=0; stall_cycles=1.
//  T3 issue long op to r9; next cycle ID reads r9 -> stall cause=3'b010, pending[9]=1;
//   lu_done r9=0xBEEF -> same cycle src_out=0xBEEF, stall=0; next cycle pending[9]=0, outstanding=0.
//  T4 MAX_OUT=4: issue long ops to r1..r4, 5th long op -> stall cause=3'b100; with lu_done same cycle -> issues,
//   outstanding stays 4.
//  T5 lu_done with outstanding=0 -> lu_err=1, pending unchanged; rst -> lu_err=0, counters 0.
//  T6 EXE and MEM both write r3 (0x11/0x22), ID reads r3 on both sources -> both 0x11; reads r0 -> rf data, no stall.

Source files
------------

// File: rtl/hazard_forward_scoreboard.sv
// ID-stage hazard unit: per-operand bypass mux (EXE / MEM / long-unit completion),
// load-use and scoreboard RAW stalls, WAW/structural stalls, and a registered
// scoreboard of destinations owned by the variable-latency long unit.
//
// Handshake: there is no valid/ready pair here. id_valid qualifies the ID
// instruction for one cycle; while stall is high the upstream holds that
// instruction and a bubble enters EXE. lu_done is a single-cycle strobe that
// is accepted unconditionally and never back-pressured.
module hazard_forward_scoreboard #(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 2,
  parameter int NREG    = 32,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 16,
  localparam int ADDR_W = $clog2(NREG)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [NUM_SRC*ADDR_W-1:0]   id_src_addr,
  input  logic [NUM_SRC-1:0]          id_src_used,
  input  logic [NUM_SRC*DATA_W-1:0]   id_src_rf,
  input  logic                        id_wr_ena,
  input  logic [ADDR_W-1:0]           id_waddr,
  input  logic                        id_is_long,
  input  logic                        exe_wr_ena,
  input  logic [ADDR_W-1:0]           exe_waddr,
  input  logic [DATA_W-1:0]           exe_wdata,
  input  logic                        exe_is_load,
  input  logic                        mem_wr_ena,
  input  logic [ADDR_W-1:0]           mem_waddr,
  input  logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_is_load,
  input  logic                        mem_load_rdy,
  input  logic                        lu_done,
  input  logic [ADDR_W-1:0]           lu_waddr,
  input  logic [DATA_W-1:0]           lu_wdata,
  output logic [NUM_SRC*DATA_W-1:0]   src_out,
  output logic                        stall,
  output logic [2:0]                  stall_cause,
  output logic [NREG-1:0]             pending,
  output logic [3:0]                  outstanding,
  output logic [CNT_W-1:0]            stall_cycles,
  output logic                        lu_err
);

  localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

  logic            load_use;
  logic            sb_raw;
  logic            waw_struct;
  logic            issue;
  logic            lu_good;
  logic [NREG-1:0] pending_nxt;
  logic [3:0]      outstanding_nxt;

  // Per-operand bypass selection and RAW hazard detection, nearest producer first.
  always_comb begin
    src_out  = id_src_rf;
    load_use = 1'b0;
    sb_raw   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i] && (id_src_addr[i*ADDR_W +: ADDR_W] != '0)) begin
        if (exe_wr_ena && (exe_waddr == id_src_addr[i*ADDR_W +: ADDR_W])) begin
          // A load in EXE has no data yet; the operand value is irrelevant while stalled.
          if (exe_is_load) load_use = 1'b1;
          else             src_out[i*DATA_W +: DATA_W] = exe_wdata;
        end else if (mem_wr_ena && (mem_waddr == id_src_addr[i*ADDR_W +: ADDR_W])) begin
          if (mem_is_load && !mem_load_rdy) load_use = 1'b1;
          else                              src_out[i*DATA_W +: DATA_W] = mem_wdata;
        end else if (lu_done && (lu_waddr == id_src_addr[i*ADDR_W +: ADDR_W])) begin
          src_out[i*DATA_W +: DATA_W] = lu_wdata;
        end else if (pending[id_src_addr[i*ADDR_W +: ADDR_W]]) begin
          sb_raw = 1'b1;
        end
      end
    end
  end

  // WAW against an in-flight long op, or no free long-unit slot this cycle.
  always_comb begin
    waw_struct = 1'b0;
    if (id_wr_ena && (id_waddr != '0) && pending[id_waddr] &&
        !(lu_done && (lu_waddr == id_waddr)))
      waw_struct = 1'b1;
    if (id_is_long && (outstanding == MAX_OUT_C) && !lu_done)
      waw_struct = 1'b1;
  end

  // Stall qualification, issue decode and scoreboard next state.
  always_comb begin
    stall_cause     = id_valid ? {waw_struct, sb_raw, load_use} : 3'b000;
    stall           = |stall_cause;
    issue           = id_valid && id_is_long && id_wr_ena && !stall && (id_waddr != '0);
    // A completion that matches nothing in flight is ignored and only flagged.
    lu_good         = lu_done && (outstanding != 4'd0) && pending[lu_waddr];
    pending_nxt     = pending;
    outstanding_nxt = outstanding;
    if (lu_good) pending_nxt[lu_waddr] = 1'b0;
    if (issue)   pending_nxt[id_waddr] = 1'b1;
    if (issue && !lu_good) begin
      if (outstanding < MAX_OUT_C) outstanding_nxt = outstanding + 4'd1;
    end else if (!issue && lu_good) begin
      outstanding_nxt = outstanding - 4'd1;
    end
  end

  // Scoreboard, error flag and stall counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending      <= '0;
      outstanding  <= 4'd0;
      stall_cycles <= '0;
      lu_err       <= 1'b0;
    end else begin
      pending     <= pending_nxt;
      outstanding <= outstanding_nxt;
      if (lu_done && !lu_good) lu_err <= 1'b1;
      if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_scoreboard.sv
// Directed bench for hazard_forward_scoreboard with hand-computed expectations.
module tb_hazard_forward_scoreboard;

  localparam int DATA_W  = 32;
  localparam int NUM_SRC = 2;
  localparam int NREG    = 32;
  localparam int ADDR_W  = 5;
  localparam int CNT_W   = 16;

  logic                      clk;
  logic                      rst;
  logic                      id_valid;
  logic [NUM_SRC*ADDR_W-1:0] id_src_addr;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [NUM_SRC*DATA_W-1:0] id_src_rf;
  logic                      id_wr_ena;
  logic [ADDR_W-1:0]         id_waddr;
  logic                      id_is_long;
  logic                      exe_wr_ena;
  logic [ADDR_W-1:0]         exe_waddr;
  logic [DATA_W-1:0]         exe_wdata;
  logic                      exe_is_load;
  logic                      mem_wr_ena;
  logic [ADDR_W-1:0]         mem_waddr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_is_load;
  logic                      mem_load_rdy;
  logic                      lu_done;
  logic [ADDR_W-1:0]         lu_waddr;
  logic [DATA_W-1:0]         lu_wdata;
  logic [NUM_SRC*DATA_W-1:0] src_out;
  logic                      stall;
  logic [2:0]                stall_cause;
  logic [NREG-1:0]           pending;
  logic [3:0]                outstanding;
  logic [CNT_W-1:0]          stall_cycles;
  logic                      lu_err;

  int n_cmp = 0;
  int n_err = 0;

  hazard_forward_scoreboard #(
    .DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .NREG(NREG), .MAX_OUT(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_src_rf(id_src_rf), .id_wr_ena(id_wr_ena),
    .id_waddr(id_waddr), .id_is_long(id_is_long), .exe_wr_ena(exe_wr_ena),
    .exe_waddr(exe_waddr), .exe_wdata(exe_wdata), .exe_is_load(exe_is_load),
    .mem_wr_ena(mem_wr_ena), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_is_load(mem_is_load), .mem_load_rdy(mem_load_rdy), .lu_done(lu_done),
    .lu_waddr(lu_waddr), .lu_wdata(lu_wdata), .src_out(src_out), .stall(stall),
    .stall_cause(stall_cause), .pending(pending), .outstanding(outstanding),
    .stall_cycles(stall_cycles), .lu_err(lu_err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic idle();
    id_valid = 0; id_src_addr = '0; id_src_used = '0;
    id_src_rf = {32'hAAAA_0001, 32'h5555_0000};
    id_wr_ena = 0; id_waddr = '0; id_is_long = 0;
    exe_wr_ena = 0; exe_waddr = '0; exe_wdata = '0; exe_is_load = 0;
    mem_wr_ena = 0; mem_waddr = '0; mem_wdata = '0; mem_is_load = 0; mem_load_rdy = 0;
    lu_done = 0; lu_waddr = '0; lu_wdata = '0;
  endtask

  // advance one clock; registered outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue_long(input logic [ADDR_W-1:0] rd);
    idle();
    id_valid = 1; id_wr_ena = 1; id_is_long = 1; id_waddr = rd;
    settle();
    chk("issue_nostall", 64'(stall), 64'd0);
    tick();
  endtask

  initial begin
    rst = 1;
    idle();
    tick();
    tick();
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_stall_cycles", 64'(stall_cycles), 64'd0);
    chk("rst_lu_err", 64'(lu_err), 64'd0);
    rst = 0;
    settle();
    chk("rst_stall", 64'(stall), 64'd0);

    // T1: EXE ALU result forwarded to src1; src0 reads r0 -> rf
    idle();
    id_valid = 1; id_src_addr = {5'd5, 5'd0}; id_src_used = 2'b11;
    exe_wr_ena = 1; exe_waddr = 5'd5; exe_wdata = 32'h1234;
    settle();
    chk("t1_src1", 64'(src_out[63:32]), 64'h1234);
    chk("t1_src0_r0", 64'(src_out[31:0]), 64'h5555_0000);
    chk("t1_stall", 64'(stall), 64'd0);
    tick();

    // T2: load-use stall, then MEM load data ready
    idle();
    id_valid = 1; id_src_addr = {5'd0, 5'd7}; id_src_used = 2'b01;
    exe_wr_ena = 1; exe_waddr = 5'd7; exe_is_load = 1;
    settle();
    chk("t2_stall", 64'(stall), 64'd1);
    chk("t2_cause", 64'(stall_cause), 64'b001);
    tick();
    chk("t2_cycles", 64'(stall_cycles), 64'd1);
    exe_wr_ena = 0; exe_is_load = 0;
    mem_wr_ena = 1; mem_waddr = 5'd7; mem_is_load = 1; mem_load_rdy = 1; mem_wdata = 32'hCAFE;
    settle();
    chk("t2_fwd", 64'(src_out[31:0]), 64'hCAFE);
    chk("t2_nostall", 64'(stall), 64'd0);
    tick();
    chk("t2_cycles_held", 64'(stall_cycles), 64'd1);

    // T3: scoreboard RAW and same-cycle completion bypass
    issue_long(5'd9);
    chk("t3_pending", 64'(pending), 64'h200);
    chk("t3_outst", 64'(outstanding), 64'd1);
    idle();
    id_valid = 1; id_src_addr = {5'd9, 5'd0}; id_src_used = 2'b10;
    settle();
    chk("t3_stall", 64'(stall), 64'd1);
    chk("t3_cause", 64'(stall_cause), 64'b010);
    tick();
    chk("t3_cycles", 64'(stall_cycles), 64'd2);
    lu_done = 1; lu_waddr = 5'd9; lu_wdata = 32'hBEEF;
    settle();
    chk("t3_fwd", 64'(src_out[63:32]), 64'hBEEF);
    chk("t3_nostall", 64'(stall), 64'd0);
    tick();
    chk("t3_pending_clr", 64'(pending), 64'd0);
    chk("t3_outst_clr", 64'(outstanding), 64'd0);
    chk("t3_lu_err", 64'(lu_err), 64'd0);

    // r0 destination never issues to the scoreboard
    idle();
    id_valid = 1; id_wr_ena = 1; id_is_long = 1; id_waddr = 5'd0;
    tick();
    chk("r0_pending", 64'(pending), 64'd0);
    chk("r0_outst", 64'(outstanding), 64'd0);

    // T4: fill the long unit, structural stall, issue alongside a completion
    issue_long(5'd1);
    issue_long(5'd2);
    issue_long(5'd3);
    issue_long(5'd4);
    chk("t4_outst_full", 64'(outstanding), 64'd4);
    chk("t4_pending", 64'(pending), 64'h1E);
    idle();
    id_valid = 1; id_wr_ena = 1; id_is_long = 1; id_waddr = 5'd10;
    settle();
    chk("t4_stall", 64'(stall), 64'd1);
    chk("t4_cause", 64'(stall_cause), 64'b100);
    tick();
    chk("t4_cycles", 64'(stall_cycles), 64'd3);
    chk("t4_outst_hold", 64'(outstanding), 64'd4);
    lu_done = 1; lu_waddr = 5'd1; lu_wdata = 32'h77;
    settle();
    chk("t4_issue_nostall", 64'(stall), 64'd0);
    tick();
    chk("t4_outst_same", 64'(outstanding), 64'd4);
    chk("t4_pending_swap", 64'(pending), 64'h41C);

    // WAW on a pending destination, then cleared by a same-cycle completion
    idle();
    id_valid = 1; id_wr_ena = 1; id_waddr = 5'd2;
    settle();
    chk("waw_cause", 64'(stall_cause), 64'b100);
    tick();
    chk("waw_cycles", 64'(stall_cycles), 64'd4);
    lu_done = 1; lu_waddr = 5'd2;
    settle();
    chk("waw_clear", 64'(stall), 64'd0);
    tick();
    chk("waw_pending", 64'(pending), 64'h418);
    chk("waw_outst", 64'(outstanding), 64'd3);

    // drain remaining long ops; stall_cause is masked without id_valid
    idle(); id_src_addr = {5'd4, 5'd3}; id_src_used = 2'b11;
    lu_done = 1; lu_waddr = 5'd3; settle();
    chk("novalid_cause", 64'(stall_cause), 64'd0);
    tick();
    lu_waddr = 5'd4; tick();
    lu_waddr = 5'd10; tick();
    chk("drain_outst", 64'(outstanding), 64'd0);
    chk("drain_pending", 64'(pending), 64'd0);

    // T5: spurious completion
    idle();
    lu_done = 1; lu_waddr = 5'd5;
    tick();
    idle();
    chk("t5_lu_err", 64'(lu_err), 64'd1);
    chk("t5_pending", 64'(pending), 64'd0);
    chk("t5_outst", 64'(outstanding), 64'd0);
    tick();
    chk("t5_lu_err_sticky", 64'(lu_err), 64'd1);

    // T6: EXE beats MEM for the same register; r0 reads the rf even with a load in EXE
    idle();
    id_valid = 1; id_src_addr = {5'd3, 5'd3}; id_src_used = 2'b11;
    exe_wr_ena = 1; exe_waddr = 5'd3; exe_wdata = 32'h11;
    mem_wr_ena = 1; mem_waddr = 5'd3; mem_wdata = 32'h22;
    settle();
    chk("t6_src0", 64'(src_out[31:0]), 64'h11);
    chk("t6_src1", 64'(src_out[63:32]), 64'h11);
    chk("t6_stall", 64'(stall), 64'd0);
    id_src_addr = {5'd0, 5'd0}; exe_waddr = 5'd0; exe_is_load = 1; mem_waddr = 5'd0;
    settle();
    chk("t6_r0_src0", 64'(src_out[31:0]), 64'h5555_0000);
    chk("t6_r0_src1", 64'(src_out[63:32]), 64'hAAAA_0001);
    chk("t6_r0_stall", 64'(stall), 64'd0);
    tick();

    // T5 cont.: reset clears error and counters
    idle();
    rst = 1;
    tick();
    rst = 0;
    chk("t5_rst_lu_err", 64'(lu_err), 64'd0);
    chk("t5_rst_cycles", 64'(stall_cycles), 64'd0);

    // reset with a long op in flight; its late completion is flagged
    issue_long(5'd6);
    chk("mid_pending", 64'(pending), 64'h40);
    idle();
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_pending", 64'(pending), 64'd0);
    chk("mid_rst_outst", 64'(outstanding), 64'd0);
    lu_done = 1; lu_waddr = 5'd6;
    tick();
    idle();
    chk("mid_late_err", 64'(lu_err), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
